// File: rtl/ctrl_sequencer_if.sv
// Handshake and strobe bundle between the fetch path, ctrl_sequencer and the datapath.
// master: opcode/flag source side; slave: the sequencer itself.
interface ctrl_sequencer_if #(
   parameter int unsigned OPW = 5,
   parameter int unsigned NT  = 4
);
   logic           Go;
   logic [OPW-1:0] opcode;
   logic           Zflag;
   logic           Cflag;
   logic           Wait;
   logic [NT-1:0]  T;
   logic           Busy;
   logic           InstrDone;
   logic           SRam_R;
   logic           SRam_W;
   logic           RegfileRead;
   logic           Regfilewrite;
   logic           OutportWrite;
   logic           INportRead;
   logic           ALU_Save;
   logic           ZFlag_Save;
   logic           CFlag_Save;
   logic           StackRead;
   logic           StackWrite;
   logic           PC_Update;

   modport master (
      output Go, opcode, Zflag, Cflag, Wait,
      input  T, Busy, InstrDone, SRam_R, SRam_W, RegfileRead, Regfilewrite,
             OutportWrite, INportRead, ALU_Save, ZFlag_Save, CFlag_Save,
             StackRead, StackWrite, PC_Update
   );

   modport slave (
      input  Go, opcode, Zflag, Cflag, Wait,
      output T, Busy, InstrDone, SRam_R, SRam_W, RegfileRead, Regfilewrite,
             OutportWrite, INportRead, ALU_Save, ZFlag_Save, CFlag_Save,
             StackRead, StackWrite, PC_Update
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired G6 control unit: one-hot T-state sequencer, instruction register and strobe decode.
// Optional memory wait-states in the T_MEM slot are enabled by defining CTRL_WAIT_EN.
module ctrl_sequencer #(
   parameter int unsigned OPW     = 5,
   parameter int unsigned NT      = 4,
   parameter int unsigned T_RD    = 0,
   parameter int unsigned T_ALU   = 1,
   parameter int unsigned T_MEM   = 2,
   parameter int unsigned T_WB    = 3,
   parameter logic [(1<<OPW)-1:0] MASK_SRAM_W = 32'h00801000,
   parameter logic [(1<<OPW)-1:0] MASK_SRAM_R = 32'h00400800,
   parameter logic [(1<<OPW)-1:0] MASK_RF_RD  = 32'h07E413FE,
   parameter logic [(1<<OPW)-1:0] MASK_RF_WR  = 32'h07580FFE,
   parameter logic [(1<<OPW)-1:0] MASK_OUT    = 32'h00200000,
   parameter logic [(1<<OPW)-1:0] MASK_ALU    = 32'h1FA417FE,
   parameter logic [(1<<OPW)-1:0] MASK_ZS     = 32'h070000FE,
   parameter logic [(1<<OPW)-1:0] MASK_CS     = 32'h07000110,
   parameter logic [(1<<OPW)-1:0] MASK_STK_W  = 32'h00040000,
   parameter logic [(1<<OPW)-1:0] MASK_STK_R  = 32'h00080000,
   parameter logic [(1<<OPW)-1:0] MASK_IN     = 32'h00100000,
   parameter logic [(1<<OPW)-1:0] MASK_PC     = 32'h00040000,
   parameter int unsigned JZ_OP   = 14,
   parameter int unsigned JNZ_OP  = 15,
   parameter int unsigned JC_OP   = 16,
   parameter int unsigned JNC_OP  = 17,
   parameter int unsigned HALT_OP = 31
) (
   input logic              clk,
   input logic              Reset,
   ctrl_sequencer_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state;
   logic [NT-1:0]  t;
   logic [OPW-1:0] ir;
   logic           stall;
   logic           br_take;

`ifdef CTRL_WAIT_EN
   // Memory not ready: freeze the sequence while in the memory slot
   assign stall = bus.Wait & t[T_MEM];
`else
   logic wait_unused;
   assign wait_unused = bus.Wait;
   assign stall       = 1'b0;
`endif

   // Sequencer: IDLE/RUN, one-hot T rotation, IR capture at instruction boundaries
   always_ff @(posedge clk) begin
      if (Reset) begin
         state <= IDLE;
         t     <= '0;
         ir    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Go) begin
                  state <= RUN;
                  t     <= NT'(1);
                  ir    <= bus.opcode;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (t[NT-1]) begin
                     if (ir == OPW'(HALT_OP)) begin
                        state <= IDLE;
                        t     <= '0;
                     end else begin
                        t  <= NT'(1);
                        ir <= bus.opcode;
                     end
                  end else begin
                     t <= {t[NT-2:0], 1'b0};
                  end
               end
            end
            default: begin
               state <= IDLE;
               t     <= '0;
            end
         endcase
      end
   end

   // Flags only matter when gated by T[T_WB] below
   assign br_take = ((ir == OPW'(JZ_OP))  &  bus.Zflag) |
                    ((ir == OPW'(JNZ_OP)) & ~bus.Zflag) |
                    ((ir == OPW'(JC_OP))  &  bus.Cflag) |
                    ((ir == OPW'(JNC_OP)) & ~bus.Cflag);

   assign bus.T         = t;
   assign bus.Busy      = (state == RUN);
   assign bus.InstrDone = t[NT-1];

   assign bus.RegfileRead  = t[T_RD]  & MASK_RF_RD[ir];
   assign bus.ALU_Save     = t[T_ALU] & MASK_ALU[ir];
   assign bus.ZFlag_Save   = t[T_ALU] & MASK_ZS[ir];
   assign bus.CFlag_Save   = t[T_ALU] & MASK_CS[ir];
   assign bus.SRam_R       = t[T_MEM] & MASK_SRAM_R[ir];
   assign bus.SRam_W       = t[T_MEM] & MASK_SRAM_W[ir];
   assign bus.StackRead    = t[T_MEM] & MASK_STK_R[ir];
   assign bus.StackWrite   = t[T_MEM] & MASK_STK_W[ir];
   assign bus.INportRead   = t[T_MEM] & MASK_IN[ir];
   assign bus.OutportWrite = t[T_MEM] & MASK_OUT[ir];
   assign bus.Regfilewrite = t[T_WB]  & MASK_RF_WR[ir];
   assign bus.PC_Update    = t[T_WB]  & (MASK_PC[ir] | br_take);

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised hardwired control unit for the G6 accumulator/register CPU. It generates its own one-hot T-state sequence, latches the opcode into an internal instruction register and decodes per-opcode strobes. The strobes drive SRAM, register file, ALU result/flag latches, stack, I/O ports and the PC. Opcode width, T-state count, strobe masks and strobe T-slots are all parameters. Conditional branching, halt and optional memory wait-states are included. It sits between the fetch path (opcode source) and the datapath.

## Interface
Parameters:
- OPW, 5: opcode width; mask width is 2**OPW.
- NT, 4: number of T-states per instruction, ≥4.
- T_RD, 0: T-slot index for RegfileRead.
- T_ALU, 1: T-slot for ALU_Save, ZFlag_Save, CFlag_Save.
- T_MEM, 2: T-slot for SRam_R, SRam_W, StackRead, StackWrite, INportRead, OutportWrite.
- T_WB, 3: T-slot for Regfilewrite, PC_Update; all slots < NT.
- MASK_SRAM_W 32'h00801000, MASK_SRAM_R 32'h00400800, MASK_RF_RD 32'h07E413FE, MASK_RF_WR 32'h07580FFE: opcode enables, bit n = opcode n.
- MASK_OUT 32'h00200000, MASK_ALU 32'h1FA417FE, MASK_ZS 32'h070000FE, MASK_CS 32'h07000110: opcode enables.
- MASK_STK_W 32'h00040000, MASK_STK_R 32'h00080000, MASK_IN 32'h00100000, MASK_PC 32'h00040000: opcode enables; MASK_PC is the unconditional PC update.
- JZ_OP 14, JNZ_OP 15, JC_OP 16, JNC_OP 17: conditional-branch opcodes.
- HALT_OP 31: halt opcode.

Ports:
- clk  in  1  clock; all state on rising edge.
- Reset  in  1  synchronous, active-high.
- Go  in  1  start pulse, honoured in IDLE only.
- opcode  in  OPW  instruction opcode from fetch.
- Zflag, Cflag  in  1 each  ALU flags, sampled combinationally in T_WB.
- Wait  in  1  memory not ready (see Configuration).
- T  out  NT  one-hot T-state; all zero in IDLE.
- Busy  out  1  high in RUN.
- InstrDone  out  1  one-cycle pulse in the final T-state of each instruction.
- SRam_R, SRam_W, RegfileRead, Regfilewrite, OutportWrite, INportRead, ALU_Save, ZFlag_Save, CFlag_Save, StackRead, StackWrite, PC_Update  out  1 each  datapath strobes.

## Operation
- Two states: IDLE and RUN. Reset forces IDLE, T=0, IR=0, and every strobe, Busy and InstrDone to 0.
- IDLE with Go=1: move to RUN, T=1 (T1), and IR<=opcode on the same edge.
- RUN: T rotates left one position per cycle. From T[NT-1], T returns to T[0] and IR<=opcode on that edge.
- Strobe s = T[slot_s] & MASK_s[IR]; combinational from the registered T and IR.
- PC_Update = T[T_WB] & (MASK_PC[IR] | (IR==JZ_OP & Zflag) | (IR==JNZ_OP & ~Zflag) | (IR==JC_OP & Cflag) | (IR==JNC_OP & ~Cflag)).
- InstrDone = T[NT-1].
- IR==HALT_OP at T[NT-1]: next state IDLE, T=0. The HALT instruction's own strobes still fire.
- Go in RUN is ignored.
- Reset mid-instruction aborts on the next edge; no partial strobes follow.

## Timing
- Latency from Go to first T1 cycle: 1 clock.
- Strobes are valid in the same cycle as their T bit; no added latency.
- One instruction takes NT cycles, plus Wait cycles when enabled.
- Back-to-back instructions have no bubble: T[NT-1] is followed directly by T[0].
- Flags are evaluated only during T[T_WB]; flag changes in other cycles have no effect.

## Configuration
- CTRL_WAIT_EN defined: Wait=1 while T[T_MEM] is active holds T and keeps the T_MEM strobes asserted. The sequencer advances on the first cycle Wait=0. Wait in any other slot is ignored.
- CTRL_WAIT_EN undefined: the Wait port exists but is ignored, and instruction length is always NT.

## Test plan
- Reset, then Go with opcode=12: T steps 0001→0010→0100→1000. SRam_W=1 only in the T3 cycle. InstrDone pulses in T4.
- opcode=14 with Zflag=1: PC_Update=1 in T4. Repeat with Zflag=0: PC_Update=0. Same check for opcode 16 with Cflag.
- opcode=11 with CTRL_WAIT_EN defined and Wait=1 for 3 cycles at T3: SRam_R stays high for 4 cycles and the instruction takes 7 cycles. Without the macro it takes 4 cycles.
- Stream opcodes 1, 2, 31: no idle cycle between instructions. Go to IDLE after the third T4, then T=0 and Busy=0.
- Assert Reset during T2: on the next edge, T=0, all strobes 0 and Busy=0. A Go pulse afterwards restarts cleanly at T1.
- Pulse Go during RUN: no effect on the T sequence or IR.
